pipelined_write_sched: RTL and testbench

- Arbitrates NUM_REQ requesters onto one shared pipelined-write bus.
- Each requester presents a complete write: command fields plus up to MAX_WR_CYCLES data beats of WR_WIDTH bits.
- The scheduler grants round-robin, then serializes the write as one write_cmd_t cycle followed by N write_dat_t cycles.
- It returns wdone pulses to the owning requester according to WRITE_TYPE_E.

---
 rtl/pipelined_write_sched.sv | 185 ++++++++++++++++++
 tb/tb_pipelined_write_sched.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_write_sched.sv
// pipelined_write_sched: round-robin arbiter that serializes one requester's
// complete write onto a shared bus as a command cycle followed by N data beats.
// It also returns wdone pulses to the owning requester.
//
// Handshake semantics (both sides): a transfer happens on a rising clock edge
// where valid and ready are both high. Requester side: req_vld & req_rdy takes
// the whole write. Bus side: out_vld & out_rdy consumes the current bus cycle.
// While out_vld is high and out_rdy is low, every out_* signal holds its value.
module pipelined_write_sched #(
  parameter int NUM_REQ       = 4,
  parameter int MAX_WR_CYCLES = 4,
  parameter int WR_WIDTH      = 8,
  localparam int NCW          = $clog2(MAX_WR_CYCLES)
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [NUM_REQ-1:0]                    req_vld,
  output logic [NUM_REQ-1:0]                    req_rdy,
  input  logic [NUM_REQ*NCW-1:0]                req_num_cycles,
  input  logic [NUM_REQ*3-1:0]                  req_write_type,
  input  logic [NUM_REQ*MAX_WR_CYCLES*WR_WIDTH-1:0] req_dat,
  output logic [NUM_REQ-1:0]                    wdone,
  output logic                                  out_vld,
  output logic                                  out_is_cmd,
  output logic [9:0]                            out_data,
  input  logic                                  out_rdy,
  output logic                                  busy
);

  localparam int RRW = $clog2(NUM_REQ);
  localparam int DW  = MAX_WR_CYCLES * WR_WIDTH;

  typedef enum logic [1:0] {IDLE = 2'd0, CMD = 2'd1, DAT = 2'd2} state_t;

  typedef struct packed {
    logic [3:0]     rsvd;
    logic           val;
    logic [NCW-1:0] num_cycles;
    logic [2:0]     write_type;
  } write_cmd_t;

  typedef struct packed {
    logic [1:0]          cycle_type;
    logic [WR_WIDTH-1:0] beat;
  } write_dat_t;

  localparam logic [1:0] CT_VALID = 2'd1;
  localparam logic [1:0] CT_DONE  = 2'd2;

  state_t              state_q, state_d;
  logic [RRW-1:0]      rr_q;
  logic [RRW-1:0]      owner_q;
  logic [NCW-1:0]      nc_q;
  logic [2:0]          wt_q;
  logic [DW-1:0]       dat_q;
  logic [NCW-1:0]      idx_q;
  logic [NUM_REQ-1:0]  wdone_q;
  logic                out_vld_q, out_is_cmd_q;
  logic [9:0]          out_data_q;

  logic                found;
  logic [RRW-1:0]      grant_idx;
  logic                grant;
  logic [NCW-1:0]      last_idx;
  logic [NCW-1:0]      nxt_idx;
  write_cmd_t          cmd_word;
  write_dat_t          dat_word;
  logic                cur_last;
  logic                wd_fire;

  // Round-robin search: first pending requester at or after the pointer.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_vld[(int'(rr_q) + i) % NUM_REQ]) begin
        found     = 1'b1;
        grant_idx = RRW'((int'(rr_q) + i) % NUM_REQ);
      end
    end
  end

  // Beat bookkeeping: index of the last beat and the beat to present next.
  always_comb begin
    last_idx = (nc_q == '0) ? NCW'(MAX_WR_CYCLES - 1) : (nc_q - 1'b1);
    nxt_idx  = (state_q == CMD) ? '0 : (idx_q + 1'b1);
    cur_last = (idx_q == last_idx);
    cmd_word.rsvd       = '0;
    cmd_word.val        = 1'b1;
    cmd_word.num_cycles = req_num_cycles[int'(grant_idx)*NCW +: NCW];
    cmd_word.write_type = req_write_type[int'(grant_idx)*3 +: 3];
    dat_word.cycle_type = (nxt_idx == last_idx) ? CT_DONE : CT_VALID;
    dat_word.beat       = dat_q[int'(nxt_idx)*WR_WIDTH +: WR_WIDTH];
  end

  // Next-state logic; arbitration only happens in IDLE.
  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    case (state_q)
      IDLE: if (found) begin
        grant   = 1'b1;
        state_d = CMD;
      end
      CMD:  if (out_rdy) state_d = DAT;
      DAT:  if (out_rdy && cur_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Write capture at grant and registered bus outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q         <= '0;
      owner_q      <= '0;
      nc_q         <= '0;
      wt_q         <= '0;
      dat_q        <= '0;
      idx_q        <= '0;
      out_vld_q    <= 1'b0;
      out_is_cmd_q <= 1'b0;
      out_data_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (grant) begin
          owner_q      <= grant_idx;
          rr_q         <= (int'(grant_idx) == NUM_REQ - 1) ? '0 : (grant_idx + 1'b1);
          nc_q         <= cmd_word.num_cycles;
          wt_q         <= cmd_word.write_type;
          dat_q        <= req_dat[int'(grant_idx)*DW +: DW];
          idx_q        <= '0;
          out_vld_q    <= 1'b1;
          out_is_cmd_q <= 1'b1;
          out_data_q   <= 10'(cmd_word);
        end
        CMD: if (out_rdy) begin
          idx_q        <= '0;
          out_is_cmd_q <= 1'b0;
          out_data_q   <= 10'(dat_word);
        end
        DAT: if (out_rdy) begin
          if (cur_last) begin
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
          end else begin
            idx_q      <= nxt_idx;
            out_data_q <= 10'(dat_word);
          end
        end
        default: out_vld_q <= 1'b0;
      endcase
    end
  end

  // wdone: per beat for MULTI_WDONE, final beat only for SINGLE_WDONE.
  assign wd_fire = (state_q == DAT) && out_rdy &&
                   ((wt_q == 3'd1) || ((wt_q == 3'd2) && cur_last));

  // One-cycle wdone pulse to the owner, one cycle after the accepted beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wdone_q <= '0;
    else        wdone_q <= wd_fire ? (NUM_REQ'(1) << owner_q) : '0;
  end

  // Accept is gated by rst_n so nothing is taken while the block is held in reset.
  assign req_rdy    = (grant && rst_n) ? (NUM_REQ'(1) << grant_idx) : '0;
  assign wdone      = wdone_q;
  assign out_vld    = out_vld_q;
  assign out_is_cmd = out_is_cmd_q;
  assign out_data   = out_data_q;
  assign busy       = (state_q != IDLE);

  a_rdy_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(req_rdy));
  a_out_stable: assert property (@(posedge clk) disable iff (!rst_n)
                                 (out_vld && !out_rdy) |=> $stable(out_data));
  a_wdone_owner: assert property (@(posedge clk) disable iff (!rst_n)
                                  (wdone & ~(NUM_REQ'(1) << owner_q)) == '0);

endmodule

// File: tb/tb_pipelined_write_sched.sv
// Testbench for pipelined_write_sched: directed writes, scoreboarded bus output
// and wdone timing, stall hold, round-robin order and mid-write reset.
module tb_pipelined_write_sched;

  localparam int NR  = 4;
  localparam int MC  = 4;
  localparam int WW  = 8;
  localparam int NCW = 2;
  localparam int W   = 15;  // {wdone expected next cycle[3:0], is_cmd, data[9:0]}

  logic                 clk;
  logic                 rst_n;
  logic [NR-1:0]        req_vld;
  logic [NR-1:0]        req_rdy;
  logic [NR*NCW-1:0]    req_num_cycles;
  logic [NR*3-1:0]      req_write_type;
  logic [NR*MC*WW-1:0]  req_dat;
  logic [NR-1:0]        wdone;
  logic                 out_vld;
  logic                 out_is_cmd;
  logic [9:0]           out_data;
  logic                 out_rdy;
  logic                 busy;

  logic [W-1:0]  exp_q[$];
  logic [NR-1:0] wd_now;
  int compared;
  int mismatched;

  pipelined_write_sched #(.NUM_REQ(NR), .MAX_WR_CYCLES(MC), .WR_WIDTH(WW)) dut (
    .clk(clk), .rst_n(rst_n), .req_vld(req_vld), .req_rdy(req_rdy),
    .req_num_cycles(req_num_cycles), .req_write_type(req_write_type),
    .req_dat(req_dat), .wdone(wdone), .out_vld(out_vld),
    .out_is_cmd(out_is_cmd), .out_data(out_data), .out_rdy(out_rdy), .busy(busy)
  );

  // Clock and reset block.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: checks wdone timing and pops the scoreboard on every accepted bus cycle.
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (!rst_n) begin
      exp_q.delete();
      wd_now = '0;
    end else begin
      if (wdone != '0 || wd_now != '0) begin
        compared++;
        if (wdone !== wd_now) begin
          mismatched++;
          $display("FAIL wdone: got %b want %b at %0t", wdone, wd_now, $time);
        end
      end
      wd_now = '0;
      if (out_vld && out_rdy) begin
        compared++;
        if (exp_q.size() == 0) begin
          mismatched++;
          $display("FAIL unexpected_bus_cycle: got is_cmd=%0b data=%h want none", out_is_cmd, out_data);
        end else begin
          e = exp_q.pop_front();
          if ({out_is_cmd, out_data} !== e[10:0]) begin
            mismatched++;
            $display("FAIL bus_cycle: got is_cmd=%0b data=%h want is_cmd=%0b data=%h",
                     out_is_cmd, out_data, e[10], e[9:0]);
          end
          wd_now = e[14:11];
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic set_req(input int r, input logic [1:0] nc, input logic [2:0] wt, input logic [31:0] dat);
    req_num_cycles[r*NCW +: NCW] = nc;
    req_write_type[r*3 +: 3]     = wt;
    req_dat[r*32 +: 32]          = dat;
  endtask

  // Expected bus cycles for one write plus the wdone each accepted beat should raise.
  task automatic push_expect(input int r, input logic [1:0] nc, input logic [2:0] wt, input logic [31:0] dat);
    logic [W-1:0]  e;
    logic [NR-1:0] wd;
    int n;
    logic last;
    e = {4'b0, 1'b1, 4'b0, 1'b1, nc, wt};
    exp_q.push_back(e);
    n = (nc == 2'd0) ? 4 : int'(nc);
    for (int i = 0; i < n; i++) begin
      last = (i == n - 1);
      wd = ((wt == 3'd1) || (wt == 3'd2 && last)) ? (4'b0001 << r) : 4'b0000;
      e = {wd, 1'b0, (last ? 2'd2 : 2'd1), dat[8*i +: 8]};
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_grant(output int g, output int idle);
    g = -1;
    idle = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!busy) idle++;
      if (req_rdy != '0) begin
        for (int i = 0; i < NR; i++) if (req_rdy[i]) g = i;
        break;
      end
    end
    if (g < 0) begin
      compared++;
      mismatched++;
      $display("FAIL grant_timeout: got no req_rdy want a grant");
    end
  endtask

  task automatic wait_drain(input string name);
    int k;
    for (k = 0; k < 200 && (exp_q.size() != 0 || busy); k++) @(negedge clk);
    if (k >= 200) begin
      compared++;
      mismatched++;
      $display("FAIL %s_drain_timeout: got %0d pending want 0", name, exp_q.size());
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  // Driver: one requester issues one write and drops valid once it is taken.
  task automatic single(input string name, input int r, input logic [1:0] nc,
                        input logic [2:0] wt, input logic [31:0] dat);
    int g, idle;
    @(posedge clk); #1;
    set_req(r, nc, wt, dat);
    req_vld[r] = 1'b1;
    wait_grant(g, idle);
    check({name, "_grant"}, g, r);
    if (g >= 0) push_expect(r, nc, wt, dat);
    @(posedge clk); #1;
    req_vld[r] = 1'b0;
  endtask

  initial begin
    int g, idle, cnt, k;
    int exp_gr[5];
    exp_gr = '{0, 1, 2, 3, 0};
    compared = 0;
    mismatched = 0;
    wd_now = '0;
    rst_n = 1'b0;
    req_vld = '0;
    req_num_cycles = '0;
    req_write_type = '0;
    req_dat = '0;
    out_rdy = 1'b1;

    // Reset values, including no accept while reset is held.
    req_vld[1] = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_req_rdy", req_rdy, 0);
    check("rst_wdone", wdone, 0);
    check("rst_out_vld", out_vld, 0);
    check("rst_out_is_cmd", out_is_cmd, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 0);
    @(posedge clk); #1;
    req_vld = '0;
    rst_n = 1'b1;

    // Single STD write, 2 beats; busy must cover CMD + 2 beats.
    @(posedge clk); #1;
    set_req(0, 2'd2, 3'd0, 32'h0000BBAA);
    req_vld[0] = 1'b1;
    wait_grant(g, idle);
    check("std_grant", g, 0);
    if (g >= 0) push_expect(0, 2'd2, 3'd0, 32'h0000BBAA);
    @(posedge clk); #1;
    req_vld[0] = 1'b0;
    cnt = 0;
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (busy) cnt++;
      else break;
    end
    check("std_busy_cycles", cnt, 3);
    wait_drain("std");

    // num_cycles=0 means 4 beats; MULTI_WDONE pulses per beat.
    single("multi", 0, 2'd0, 3'd1, 32'h44332211);
    wait_drain("multi");

    // SINGLE_WDONE, 3 beats, beat1 stalled for 5 cycles.
    single("single", 0, 2'd3, 3'd2, 32'h00CCBBAA);
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (out_vld && !out_is_cmd) break;
    end
    @(posedge clk); #1;
    out_rdy = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("stall_hold", {out_vld, out_is_cmd, out_data}, {1'b1, 1'b0, 10'h1BB});
    end
    @(posedge clk); #1;
    out_rdy = 1'b1;
    wait_drain("single");

    // Reserved write_type passes through the command field and gives no wdone.
    single("wt5", 0, 2'd1, 3'd5, 32'h00000077);
    wait_drain("wt5");

    // Reset during beat 2 of a MULTI_WDONE write from requester 2.
    single("rstmid", 2, 2'd0, 3'd1, 32'h44332211);
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (out_vld && !out_is_cmd && out_data[7:0] == 8'h22) break;
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("rstmid_out_vld", out_vld, 0);
    check("rstmid_out_is_cmd", out_is_cmd, 0);
    check("rstmid_out_data", out_data, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_wdone", wdone, 0);
    repeat (2) begin
      @(negedge clk);
      check("rstmid_wdone_held", wdone, 0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    set_req(0, 2'd1, 3'd0, 32'h00000055);
    set_req(3, 2'd2, 3'd2, 32'h00006655);
    req_vld[0] = 1'b1;
    req_vld[3] = 1'b1;
    wait_grant(g, idle);
    check("post_rst_grant", g, 0);
    if (g >= 0) push_expect(0, 2'd1, 3'd0, 32'h00000055);
    @(posedge clk); #1;
    req_vld[0] = 1'b0;
    wait_grant(g, idle);
    check("post_rst_grant2", g, 3);
    if (g >= 0) push_expect(3, 2'd2, 3'd2, 32'h00006655);
    @(posedge clk); #1;
    req_vld[3] = 1'b0;
    wait_drain("rstmid");

    // All four requesters held valid: round-robin order, one idle cycle between writes.
    @(posedge clk); #1;
    for (int r = 0; r < NR; r++) set_req(r, 2'd1, 3'd1, 32'hA0 + r);
    req_vld = '1;
    for (int n = 0; n < 5; n++) begin
      wait_grant(g, idle);
      check("rr_grant", g, exp_gr[n]);
      if (n > 0) check("rr_idle_cycles", idle, 1);
      if (g >= 0) push_expect(g, 2'd1, 3'd1, 32'hA0 + g);
      @(posedge clk); #1;
      if (n == 4) req_vld = '0;
    end
    wait_drain("rr");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
